// File: rtl/huff_pkg.sv
// Shared types and constants for the bit-serial Huffman decoder.
// Provides the table size, the decoder state enum, the code-entry struct
// and a helper that turns a contiguous code mask into a code length.
package huff_pkg;

  localparam int unsigned MAX_CHAR_COUNT = 5;
  localparam int unsigned CNT_W          = $clog2(MAX_CHAR_COUNT + 1);

  typedef enum logic [2:0] {
    UNLOADED = 3'd0,
    SHIFT    = 3'd1,
    CHECK    = 3'd2,
    EMIT     = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } huff_dec_state_t;

  // One decoded table entry; len == 0 marks an entry that can never match.
  typedef struct packed {
    logic [7:0]                ch;
    logic [MAX_CHAR_COUNT-1:0] value;
    logic [MAX_CHAR_COUNT-1:0] mask;
    logic [CNT_W-1:0]          len;
  } huff_code_t;

  // Number of set bits in a code mask, i.e. the code length.
  function automatic logic [CNT_W-1:0] code_len(input logic [MAX_CHAR_COUNT-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/huff_code_match.sv
// Combinational code lookup: compares the accumulated code word against
// every valid table entry and reports the lowest matching index.
// Ports:
//   tbl               loaded code table
//   acc               accumulated code bits, right-aligned (last bit in bit 0)
//   len               number of bits accumulated
//   unique_char_count number of valid table entries
//   hit               some entry matched
//   hit_index         lowest matching entry index
module huff_code_match
  import huff_pkg::*;
(
  input  huff_code_t [MAX_CHAR_COUNT-1:0] tbl,
  input  logic [MAX_CHAR_COUNT-1:0]       acc,
  input  logic [CNT_W-1:0]                len,
  input  logic [CNT_W-1:0]                unique_char_count,
  output logic                            hit,
  output logic [CNT_W-1:0]                hit_index
);

  // Ascending scan; the first hit locks out later entries.
  always_comb begin
    hit       = 1'b0;
    hit_index = '0;
    for (int unsigned i = 0; i < MAX_CHAR_COUNT; i++) begin
      if (!hit &&
          (CNT_W'(i) < unique_char_count) &&
          (tbl[i].len != '0) &&
          (tbl[i].len == len) &&
          ((acc & tbl[i].mask) == (tbl[i].value & tbl[i].mask))) begin
        hit       = 1'b1;
        hit_index = CNT_W'(i);
      end
    end
  end

endmodule

// File: rtl/huff_decoder.sv
// Bit-serial Huffman decoder. Loads the encoder's code table, shifts in one
// code bit per handshake (MSB of each code first) and emits one decoded
// character per handshake; done is raised after the last coded symbol.
// Optional macro HUFF_DEC_ERR_EN: when defined, an unmatched code parks the
// decoder in ERR with a sticky error flag; when undefined, error is tied low,
// unmatched full-length codes are dropped and an unmatched final bit ends the
// stream without a character.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   tbl_load             one-cycle pulse capturing the table inputs below
//   character            packed 8-bit characters, entry i at [8i+7:8i]
//   encoded_value        packed code words, right-aligned per entry
//   encoded_mask         packed contiguous valid-bit masks per entry
//   unique_char_count    number of valid entries
//   bit_in/last/valid    encoded bit stream input, bit_ready back-pressure
//   char_out/char_valid  decoded character output, char_ready back-pressure
//   done                 sticky: final symbol delivered
//   error                sticky invalid-code flag
module huff_decoder
  import huff_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     tbl_load,
  input  logic [MAX_CHAR_COUNT*8-1:0]              character,
  input  logic [MAX_CHAR_COUNT*MAX_CHAR_COUNT-1:0] encoded_value,
  input  logic [MAX_CHAR_COUNT*MAX_CHAR_COUNT-1:0] encoded_mask,
  input  logic [CNT_W-1:0]                         unique_char_count,
  input  logic                                     bit_in,
  input  logic                                     bit_last,
  input  logic                                     bit_valid,
  output logic                                     bit_ready,
  output logic [7:0]                               char_out,
  output logic                                     char_valid,
  input  logic                                     char_ready,
  output logic                                     done,
  output logic                                     error
);

  localparam int unsigned W = MAX_CHAR_COUNT;

  huff_dec_state_t     state_q, state_d;
  huff_code_t [W-1:0]  tbl_q, tbl_d, ld_tbl;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    max_len_q, max_len_d, ld_max_len;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [W-1:0]        acc_q, acc_d;
  logic                last_q, last_d;
  logic [7:0]          char_out_q, char_out_d;
  logic                char_valid_q, char_valid_d;
  logic                bit_ready_q, bit_ready_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                hit;
  logic [CNT_W-1:0]    hit_index;

  // Table image as it would be captured by a load this cycle.
  always_comb begin
    ld_tbl     = '0;
    ld_max_len = '0;
    for (int unsigned i = 0; i < W; i++) begin
      ld_tbl[i].ch    = character[8*i +: 8];
      ld_tbl[i].value = encoded_value[W*i +: W];
      ld_tbl[i].mask  = encoded_mask[W*i +: W];
      ld_tbl[i].len   = (CNT_W'(i) < unique_char_count) ?
                        code_len(encoded_mask[W*i +: W]) : '0;
    end
    // A lone symbol is always the one-bit code "0", whatever its mask says.
    if (unique_char_count == CNT_W'(1)) begin
      ld_tbl[0].value = '0;
      ld_tbl[0].mask  = W'(1);
      ld_tbl[0].len   = CNT_W'(1);
    end
    for (int unsigned i = 0; i < W; i++) begin
      if (ld_tbl[i].len > ld_max_len) begin
        ld_max_len = ld_tbl[i].len;
      end
    end
  end

  huff_code_match u_match (
    .tbl               (tbl_q),
    .acc               (acc_q),
    .len               (len_q),
    .unique_char_count (count_q),
    .hit               (hit),
    .hit_index         (hit_index)
  );

  // Next-state and output logic; a table load wins over everything else.
  always_comb begin
    state_d      = state_q;
    tbl_d        = tbl_q;
    count_d      = count_q;
    max_len_d    = max_len_q;
    acc_d        = acc_q;
    len_d        = len_q;
    last_d       = last_q;
    char_out_d   = char_out_q;
    char_valid_d = char_valid_q;
    done_d       = done_q;
    error_d      = error_q;

    if (tbl_load) begin
      tbl_d        = ld_tbl;
      count_d      = unique_char_count;
      max_len_d    = ld_max_len;
      acc_d        = '0;
      len_d        = '0;
      last_d       = 1'b0;
      char_valid_d = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      state_d      = (unique_char_count == '0) ? UNLOADED : SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          if (bit_valid) begin
            acc_d   = {acc_q[W-2:0], bit_in};
            len_d   = len_q + CNT_W'(1);
            last_d  = bit_last;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            char_out_d   = tbl_q[hit_index].ch;
            char_valid_d = 1'b1;
            acc_d        = '0;
            len_d        = '0;
            state_d      = EMIT;
          end else if (!last_q && (len_q < max_len_q)) begin
            state_d = SHIFT;
          end else begin
`ifdef HUFF_DEC_ERR_EN
            error_d = 1'b1;
            state_d = ERR;
`else
            // Drop the unusable code word and carry on, or finish quietly.
            acc_d = '0;
            len_d = '0;
            if (last_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
`endif
          end
        end
        EMIT: begin
          if (char_ready) begin
            char_valid_d = 1'b0;
            if (last_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        default: begin
          // UNLOADED, DONE and ERR hold until reset or a table load.
        end
      endcase
    end

    // Registered ready: high exactly while the next state is SHIFT.
    bit_ready_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= UNLOADED;
      tbl_q        <= '0;
      count_q      <= '0;
      max_len_q    <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      last_q       <= 1'b0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      bit_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tbl_q        <= tbl_d;
      count_q      <= count_d;
      max_len_q    <= max_len_d;
      acc_q        <= acc_d;
      len_q        <= len_d;
      last_q       <= last_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      bit_ready_q  <= bit_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bit_ready  = bit_ready_q;
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_huff_decoder.sv
// Self-checking bench for huff_decoder: directed table of vectors, hand-written
// multi-cycle sequences and randomized tables/streams against a prefix-parse model.
module tb_huff_decoder;
  import huff_pkg::*;

  localparam int unsigned N = MAX_CHAR_COUNT;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tbl_load;
  logic [N*8-1:0]       character;
  logic [N*N-1:0]       encoded_value;
  logic [N*N-1:0]       encoded_mask;
  logic [CNT_W-1:0]     unique_char_count;
  logic                 bit_in, bit_last, bit_valid, bit_ready;
  logic [7:0]           char_out;
  logic                 char_valid, char_ready;
  logic                 done, error;

  int total = 0;
  int bad   = 0;

  // Model-side view of the current table (used for random runs).
  int         t_cnt;
  int         t_len [N];
  int         t_val [N];
  logic [7:0] t_ch  [N];

  always #5 clk = ~clk;

  huff_decoder dut (
    .clk               (clk),
    .reset             (reset),
    .tbl_load          (tbl_load),
    .character         (character),
    .encoded_value     (encoded_value),
    .encoded_mask      (encoded_mask),
    .unique_char_count (unique_char_count),
    .bit_in            (bit_in),
    .bit_last          (bit_last),
    .bit_valid         (bit_valid),
    .bit_ready         (bit_ready),
    .char_out          (char_out),
    .char_valid        (char_valid),
    .char_ready        (char_ready),
    .done              (done),
    .error             (error)
  );

  typedef struct {
    string          name;
    int             cnt;
    logic [N*8-1:0] chs;
    logic [N*N-1:0] vals;
    logic [N*N-1:0] masks;
    string          bits;
    int             nsend;
    string          exp;
    bit             ed;
    bit             ee;
  } vec_t;

  function automatic vec_t mk(input string name, input int cnt, input logic [N*8-1:0] chs,
                              input logic [N*N-1:0] vals, input logic [N*N-1:0] masks,
                              input string bits, input int nsend, input string exp,
                              input bit ed, input bit ee);
    vec_t v;
    v.name = name; v.cnt = cnt; v.chs = chs; v.vals = vals; v.masks = masks;
    v.bits = bits; v.nsend = nsend; v.exp = exp; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [N*8-1:0] chs, input logic [N*N-1:0] vals,
                      input logic [N*N-1:0] masks, input int cnt);
    character         = chs;
    encoded_value     = vals;
    encoded_mask      = masks;
    unique_char_count = CNT_W'(cnt);
    tbl_load          = 1'b1;
    @(negedge clk);
    tbl_load          = 1'b0;
  endtask

  task automatic send_bit(input bit b, input bit last);
    int k;
    k = 0;
    bit_in = b; bit_last = last; bit_valid = 1'b1;
    while (!bit_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("send_bit_ready", 32'(bit_ready), 32'd1);
    @(negedge clk);
    bit_valid = 1'b0;
    bit_last  = 1'b0;
  endtask

  task automatic wait_char(input string name, input logic [7:0] want);
    int k;
    k = 0;
    while (!char_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'({char_valid, char_out}), 32'({1'b1, want}));
    @(negedge clk);
  endtask

  // Reference: walk the bit string as a prefix parse over the code set.
  task automatic model(input string bits, output logic [7:0] exp[$], output int nsend,
                       output bit ed, output bit ee);
    int L [N];
    int V [N];
    int maxl, acc, len, hit;
    bit last;
    exp.delete();
    nsend = 0; ed = 1'b0; ee = 1'b0; maxl = 0; acc = 0; len = 0;
    for (int i = 0; i < N; i++) begin
      L[i] = (i < t_cnt) ? t_len[i] : 0;
      V[i] = t_val[i] & ((1 << L[i]) - 1);
    end
    if (t_cnt == 1) begin
      L[0] = 1;
      V[0] = 0;
    end
    for (int i = 0; i < N; i++) if (L[i] > maxl) maxl = L[i];
    for (int k = 0; k < bits.len(); k++) begin
      last  = (k == bits.len() - 1);
      acc   = acc * 2 + ((bits[k] == "1") ? 1 : 0);
      len   = len + 1;
      nsend = nsend + 1;
      hit   = -1;
      for (int i = 0; i < N; i++) begin
        if (hit < 0 && L[i] > 0 && L[i] == len && V[i] == acc) hit = i;
      end
      if (hit >= 0) begin
        exp.push_back(t_ch[hit]);
        acc = 0; len = 0;
        ed  = last;
      end else if (last || len >= maxl) begin
`ifdef HUFF_DEC_ERR_EN
        ee = 1'b1;
        break;
`else
        acc = 0; len = 0;
        ed  = last;
`endif
      end
    end
  endtask

  // Drive a stream and score the output characters and final flags.
  task automatic run_stream(input string name, input string bits, input int nsend,
                            input logic [7:0] exp[$], input bit ed, input bit ee, input bit rnd);
    int idx, got, cyc;
    bit hold;
    logic [7:0] held;
    idx = 0; got = 0; cyc = 0; hold = 1'b0; held = 8'h00;
    while (!(done || error) && cyc < 3000) begin
      if (idx < nsend) begin
        bit_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        bit_in    = (bits[idx] == "1");
        bit_last  = (idx == bits.len() - 1);
      end else begin
        bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
      end
      char_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (hold) check({name, ":hold"}, 32'({char_valid, char_out}), 32'({1'b1, held}));
      if (bit_ready && bit_valid) idx++;
      if (char_valid && char_ready) begin
        if (got < exp.size()) check({name, ":char"}, 32'(char_out), 32'(exp[got]));
        else check({name, ":extra_char"}, 32'(got), 32'(exp.size()));
        got++;
        hold = 1'b0;
      end else begin
        hold = char_valid;
        held = char_out;
      end
      @(negedge clk);
      cyc++;
    end
    bit_valid = 1'b0; bit_last = 1'b0;
    check({name, ":nchars"}, 32'(got), 32'(exp.size()));
    check({name, ":nbits"}, 32'(idx), 32'(nsend));
    check({name, ":done"}, 32'(done), 32'(ed));
    check({name, ":error"}, 32'(error), 32'(ee));
    check({name, ":ready_off"}, 32'(bit_ready), 32'd0);
  endtask

  localparam logic [N*8-1:0] CH_ABC = {8'h00, 8'h00, "c", "b", "a"};
  localparam logic [N*N-1:0] V_ABC  = {5'd0, 5'd0, 5'b00011, 5'b00010, 5'b00000};
  localparam logic [N*N-1:0] M_ABC  = {5'd0, 5'd0, 5'b00011, 5'b00011, 5'b00001};
  localparam logic [N*N-1:0] V_AB   = {5'd0, 5'd0, 5'd0, 5'b00010, 5'b00000};
  localparam logic [N*N-1:0] M_AB   = {5'd0, 5'd0, 5'd0, 5'b00011, 5'b00001};

  vec_t vecs [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [N*8-1:0] chs;
    logic [N*N-1:0] vals, masks;
    logic [7:0]     q[$];
    string          s, one, zero;
    int             ns, nb, e, guard;
    bit             ed, ee;

    one = "1"; zero = "0";
    vecs[0] = mk("abc", 3, CH_ABC, V_ABC, M_ABC, "10011", 5, "bac", 1'b1, 1'b0);
    vecs[1] = mk("single", 1, {32'h0, "a"}, '0, '0, "000", 3, "aaa", 1'b1, 1'b0);
`ifdef HUFF_DEC_ERR_EN
    vecs[2] = mk("bad_full", 2, {24'h0, "b", "a"}, V_AB, M_AB, "110", 2, "", 1'b0, 1'b1);
    vecs[3] = mk("bad_last", 2, {24'h0, "b", "a"}, V_AB, M_AB, "1", 1, "", 1'b0, 1'b1);
    vecs[4] = mk("ignored", 2, {16'h0, "r", "q", "p"}, {15'd0, 5'd1, 5'd0},
                 {10'd0, 5'd1, 5'd1, 5'd0}, "10", 2, "q", 1'b0, 1'b1);
    vecs[8] = mk("single_one", 1, {32'h0, "a"}, '0, '0, "1", 1, "", 1'b0, 1'b1);
`else
    vecs[2] = mk("bad_full", 2, {24'h0, "b", "a"}, V_AB, M_AB, "110", 3, "a", 1'b1, 1'b0);
    vecs[3] = mk("bad_last", 2, {24'h0, "b", "a"}, V_AB, M_AB, "1", 1, "", 1'b1, 1'b0);
    vecs[4] = mk("ignored", 2, {16'h0, "r", "q", "p"}, {15'd0, 5'd1, 5'd0},
                 {10'd0, 5'd1, 5'd1, 5'd0}, "10", 2, "q", 1'b1, 1'b0);
    vecs[8] = mk("single_one", 1, {32'h0, "a"}, '0, '0, "1", 1, "", 1'b1, 1'b0);
`endif
    vecs[5] = mk("lowest_idx", 2, {24'h0, "n", "m"}, {15'd0, 5'b01, 5'b01},
                 {15'd0, 5'b11, 5'b11}, "01", 2, "m", 1'b1, 1'b0);
    vecs[6] = mk("len5", 2, {24'h0, "z", "y"}, {15'd0, 5'b10110, 5'b00000},
                 {15'd0, 5'b11111, 5'b00001}, "101100", 6, "zy", 1'b1, 1'b0);
    vecs[7] = mk("single_mask", 1, {32'h0, "a"}, {20'd0, 5'd3}, {20'd0, 5'd3},
                 "0", 1, "a", 1'b1, 1'b0);
    vecs[9] = mk("val_masked", 2, {24'h0, "b", "a"}, {15'd0, 5'b11101, 5'b11110},
                 {15'd0, 5'b00001, 5'b00001}, "10", 2, "ba", 1'b1, 1'b0);

    reset = 1'b1; tbl_load = 1'b0; character = '0; encoded_value = '0; encoded_mask = '0;
    unique_char_count = '0; bit_in = 1'b0; bit_last = 1'b0; bit_valid = 1'b0; char_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_char_out", 32'(char_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("unloaded_ready", 32'(bit_ready), 32'd0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      q.delete();
      for (int k = 0; k < vecs[i].exp.len(); k++) q.push_back(vecs[i].exp[k]);
      load(vecs[i].chs, vecs[i].vals, vecs[i].masks, vecs[i].cnt);
      check({vecs[i].name, ":load_ready"}, 32'(bit_ready), 32'd1);
      run_stream(vecs[i].name, vecs[i].bits, vecs[i].nsend, q, vecs[i].ed, vecs[i].ee, 1'b0);
    end

    // Latency and backpressure.
    load(CH_ABC, V_ABC, M_ABC, 3);
    check("reload_clears_done", 32'(done), 32'd0);
    char_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("lat_pre", 32'(char_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'({char_valid, char_out}), 32'({1'b1, 8'("b")}));
    for (int c = 0; c < 5; c++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge clk);
      check("bp_char", 32'({char_valid, char_out}), 32'({1'b1, 8'("b")}));
      check("bp_ready", 32'(bit_ready), 32'd0);
    end
    bit_valid = 1'b0; char_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(char_valid), 32'd0);
    send_bit(1'b0, 1'b0);
    wait_char("bp_a", 8'("a"));
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    wait_char("bp_c", 8'("c"));
    check("bp_done", 32'({done, error, bit_ready}), 32'({1'b1, 1'b0, 1'b0}));

    // Mid-stream reload with a competing bit handshake.
    load({24'h0, "b", "a"}, V_AB, M_AB, 2);
    check("reload_done_clr", 32'(done), 32'd0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = 1'b0; bit_last = 1'b1;
    load({24'h0, "y", "x"}, {15'd0, 5'd0, 5'd1}, {15'd0, 5'd1, 5'd1}, 2);
    bit_valid = 1'b0; bit_last = 1'b0;
    check("reload_bit_dropped", 32'({bit_ready, char_valid, done, error}), 32'({4'b1000}));
    send_bit(1'b1, 1'b1);
    wait_char("reload_x", 8'("x"));
    check("reload_done", 32'({done, error}), 32'({2'b10}));

    // Reset while a character is waiting.
    load(CH_ABC, V_ABC, M_ABC, 3);
    char_ready = 1'b0;
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    check("emit_before_rst", 32'(char_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_emit", 32'({char_valid, bit_ready, char_out, done}), 32'({1'b0, 1'b0, 8'h00, 1'b0}));
    bit_valid = 1'b1; bit_in = 1'b0; bit_last = 1'b1; char_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ignore", 32'({bit_ready, char_valid, done}), 32'd0);
    end
    bit_valid = 1'b0; bit_last = 1'b0;

    // Zero-entry load keeps the decoder idle, also from SHIFT.
    load(CH_ABC, V_ABC, M_ABC, 0);
    @(negedge clk);
    check("cnt0_idle", 32'(bit_ready), 32'd0);
    load(CH_ABC, V_ABC, M_ABC, 3);
    load(CH_ABC, V_ABC, M_ABC, 0);
    @(negedge clk);
    check("cnt0_from_shift", 32'(bit_ready), 32'd0);

    // Randomized tables and streams.
    for (int it = 0; it < 40; it++) begin
      chs = '0; vals = '0; masks = '0;
      t_cnt = $urandom_range(1, N);
      for (int i = 0; i < N; i++) begin
        t_len[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, N));
        t_val[i] = $urandom_range(0, 31);
        t_ch[i]  = 8'($urandom_range(33, 126));
        chs[8*i +: 8]  = t_ch[i];
        vals[N*i +: N] = N'(t_val[i]);
        masks[N*i +: N] = N'((1 << t_len[i]) - 1);
      end
      nb = $urandom_range(1, 14);
      s  = "";
      if ($urandom_range(0, 1) == 1) begin
        guard = 0;
        while (s.len() < nb && guard < 20) begin
          e = $urandom_range(0, t_cnt - 1);
          guard++;
          if (t_cnt == 1) s = {s, zero};
          else for (int b = t_len[e] - 1; b >= 0; b--) s = {s, (((t_val[e] >> b) & 1) != 0) ? one : zero};
        end
      end
      while (s.len() < nb) s = {s, ($urandom_range(0, 1) == 1) ? one : zero};
      load(chs, vals, masks, t_cnt);
      model(s, q, ns, ed, ee);
      run_stream($sformatf("rnd%0d", it), s, ns, q, ed, ee, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huff_decoder.md
Name: huff_decoder

Overview:
Bit-serial Huffman decoder, the receive-side counterpart of huff_encoder.
- Loads the code table the encoder produces (character, encoded_value, encoded_mask, unique_char_count).
- Consumes the encoded bitstream one bit per handshake and emits one decoded 8-bit character per handshake.
- Asserts done after the last coded symbol.

Parameters:
MAX_CHAR_COUNT, 5, max table entries; also width of each code word and max code length
CNT_W, $clog2(MAX_CHAR_COUNT+1), width of unique_char_count and internal length counters

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
tbl_load  in  1  single-cycle pulse: capture table inputs
character  in  MAX_CHAR_COUNT*8  packed; entry i = bits [8i+7:8i]
encoded_value  in  MAX_CHAR_COUNT*MAX_CHAR_COUNT  entry i code, right-aligned
encoded_mask  in  MAX_CHAR_COUNT*MAX_CHAR_COUNT  entry i valid-bit mask, contiguous from bit 0
unique_char_count  in  CNT_W  number of valid entries (0..MAX_CHAR_COUNT)
bit_in  in  1  encoded bit
bit_last  in  1  qualifies bit_in as final bit of stream
bit_valid  in  1  bit_in valid
bit_ready  out  1  decoder accepts bit this cycle
char_out  out  8  decoded character
char_valid  out  1  char_out valid; held until accepted
char_ready  in  1  downstream accepts char_out
done  out  1  sticky: final symbol delivered
error  out  1  sticky invalid-code flag (see Optional Feature)

Behaviour:
- Reset (sync, high): state=UNLOADED; bit_ready=0, char_valid=0, char_out=8'h00, done=0, error=0; accumulator and length cleared.
- Code convention:
  - code length L_i = popcount(encoded_mask[i]).
  - Transmission is MSB first: bit L_i-1 first, bit 0 last.
  - Entries with index >= unique_char_count, or with mask==0, are ignored.
- Single-symbol table (unique_char_count==1): entry 0 is treated as code "0", L=1, regardless of its mask.
- tbl_load:
  - Captures all table inputs in one cycle.
  - Computes max_len = max L_i over valid entries.
  - Clears accumulator, done, error, char_valid; next state SHIFT.
  - Accepted in any state and overrides a same-cycle bit handshake.
  - unique_char_count==0 at load: stay UNLOADED.
- FSM:
  - UNLOADED: bit_ready=0. On tbl_load -> SHIFT.
  - SHIFT: bit_ready=1. On bit_valid: acc<={acc[MAX_CHAR_COUNT-2:0],bit_in}; len<=len+1; last_q<=bit_last; -> CHECK.
  - CHECK: bit_ready=0. Compare acc/len against every valid entry (len==L_i and acc&mask_i==value_i&mask_i); lowest matching index wins.
    - Match: char_out<=character[i]; char_valid<=1; clear acc/len; -> EMIT.
    - No match and len<max_len and !last_q: -> SHIFT.
    - No match and (len==max_len or last_q): -> ERR.
  - EMIT: char_valid held, char_out stable until char_valid&&char_ready. On the handshake: char_valid<=0; if last_q, done<=1 and -> DONE, else -> SHIFT.
  - DONE: bit_ready=0, done=1 until reset or tbl_load.
  - ERR: bit_ready=0, error=1 until reset or tbl_load.
- Latency and throughput:
  - Bit accepted at edge e; char_valid is high from edge e+1 when that bit completes a code.
  - Max throughput is one bit per 2 cycles.
- Reset mid-operation: returns to UNLOADED; table contents discarded.

Optional Feature:
Macro HUFF_DEC_ERR_EN.
- Defined: ERR state and sticky error output as above.
- Undefined: error tied 0 and ERR state removed.
  - An unmatched code at len==max_len is silently discarded: acc/len cleared, -> SHIFT.
  - An unmatched code with last_q set -> DONE, with no character emitted.

Decomposition:
- Package huff_pkg:
  - MAX_CHAR_COUNT default.
  - huff_dec_state_t enum {UNLOADED, SHIFT, CHECK, EMIT, DONE, ERR}.
  - code-entry struct {logic [7:0] ch; logic [MAX_CHAR_COUNT-1:0] value, mask; logic [CNT_W-1:0] len;}.
- One sub-module: huff_code_match, combinational.
  - Inputs: table array, acc, len, unique_char_count.
  - Outputs: hit, hit_index (lowest index first).

Test Plan:
- Table {a:"0",b:"10",c:"11"}, count 3, char_ready=1; stream 1,0,0,1,1(last) -> chars 'b','a','c' in order, then done=1, error=0.
- Single-symbol table {a}, count 1; stream 0,0,0(last) -> three 'a', done=1.
- Backpressure: same 3-entry table, char_ready=0 for 5 cycles after first char_valid -> char_out='b' stable, bit_ready=0 throughout; release -> decode resumes with no bit lost.
- Invalid code, table {a:"0",b:"10"} (max_len 2); stream 1,1 -> with HUFF_DEC_ERR_EN: error=1, bit_ready=0 thereafter; without: no output, decoder back in SHIFT, next 0 -> 'a'.
- Mid-stream reload: send 1, then tbl_load with {x:"1",y:"0"} -> acc cleared, done/error cleared; stream 1(last) -> 'x', done=1.
- Reset asserted while in EMIT -> next cycle char_valid=0, bit_ready=0, char_out=8'h00; bits ignored until tbl_load.
